circ_seq_fsm: RTL and testbench

- Parametrised top-level sequencer for the circuit generator.
- Decodes a received command byte into one of three modes: sample+send, sample-only or send-only.
- Sampling: streams 2^ADDR_W samples into capture memory.
- Sending: replays memory bytes to the serial transmitter with a ready handshake.
- A watchdog aborts any stalled phase.

---
 rtl/circ_seq_fsm.sv | 170 +++++++++++++++++
 tb/tb_circ_seq_fsm.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/circ_seq_fsm.sv
// circ_seq_fsm: command-driven sample/send sequencer with stall watchdog.
// Optional build macro CIRC_SEQ_FSM_ABORT_EN: 8'hFF received while busy aborts the run.
module circ_seq_fsm #(
    parameter int ADDR_W    = 8,
    parameter int TIMEOUT_W = 16
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iRxDone,
    input  logic [7:0]        iRxData,
    input  logic              iSampleValid,
    input  logic              iTxReady,
    output logic              oFetchValue,
    output logic              oResetSerial,
    output logic              oStartSampling,
    output logic              oMemWrite,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic              oTxStart,
    output logic              oBusy,
    output logic              oDone,
    output logic              oError
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_SAMPLE,
        S_SEND_RD,
        S_SEND_WAIT,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_SAMPLE_SEND = 2'b00;
    localparam logic [1:0] MODE_SEND_ONLY   = 2'b10;
    localparam logic [1:0] MODE_IGNORED     = 2'b11;

    localparam logic [ADDR_W-1:0]    LAST    = '1;
    localparam logic [TIMEOUT_W-1:0] WD_ZERO = '0;
    // Terminal compare one below all-ones: the stall that brings the count to all-ones fires.
    localparam logic [TIMEOUT_W-1:0] WD_TERM = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [TIMEOUT_W-1:0]  wd_q, wd_d;
    logic                  err_q, err_d;
    logic                  abort;

`ifdef CIRC_SEQ_FSM_ABORT_EN
    assign abort = iRxDone && (iRxData == 8'hFF) &&
                   (state_q != S_IDLE) && (state_q != S_DONE);
`else
    assign abort = 1'b0;
`endif

    logic unused_rx;
    assign unused_rx = ^iRxData[5:0];

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_SAMPLE_SEND;
            addr_q  <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        wd_d    = WD_ZERO;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (iRxDone && (iRxData[7:6] != MODE_IGNORED)) begin
                    mode_d  = iRxData[7:6];
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                addr_d  = '0;
                state_d = (mode_q == MODE_SEND_ONLY) ? S_SEND_RD : S_START;
            end
            S_START: begin
                addr_d  = '0;
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (iSampleValid) begin
                    if (addr_q == LAST) begin
                        addr_d  = '0;
                        state_d = (mode_q == MODE_SAMPLE_SEND) ? S_SEND_RD : S_DONE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end else if (wd_q == WD_TERM) begin
                    err_d   = 1'b1;
                    addr_d  = '0;
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_SEND_RD: begin
                state_d = S_SEND_WAIT;
            end
            S_SEND_WAIT: begin
                if (iTxReady) begin
                    if (addr_q == LAST) begin
                        addr_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_SEND_RD;
                    end
                end else if (wd_q == WD_TERM) begin
                    err_d   = 1'b1;
                    addr_d  = '0;
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort) begin
            err_d   = 1'b1;
            addr_d  = '0;
            wd_d    = WD_ZERO;
            state_d = S_DONE;
        end
    end

    always_comb begin
        oFetchValue    = 1'b0;
        oStartSampling = 1'b0;
        oResetSerial   = 1'b0;
        oDone          = 1'b0;
        oBusy          = (state_q != S_IDLE);
        oMemWrite      = (state_q == S_SAMPLE) && iSampleValid && !abort;
        oTxStart       = (state_q == S_SEND_WAIT) && iTxReady && !abort;
        oMemAddr       = addr_q;
        oError         = err_q;
        unique case (state_q)
            S_FETCH: oFetchValue = 1'b1;
            S_START: begin
                oStartSampling = 1'b1;
                oResetSerial   = 1'b1;
            end
            S_DONE:  oDone = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_circ_seq_fsm.sv
// tb_circ_seq_fsm: randomized scoreboard bench for circ_seq_fsm (ADDR_W=2, TIMEOUT_W=4).
// Expected events come from a command-level model; a negedge monitor pops and compares.
module tb_circ_seq_fsm;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          iReset, iRxDone, iSampleValid, iTxReady;
    logic [7:0]    iRxData;
    logic          oFetchValue, oResetSerial, oStartSampling, oMemWrite;
    logic [AW-1:0] oMemAddr;
    logic          oTxStart, oBusy, oDone, oError;

    circ_seq_fsm #(.ADDR_W(AW), .TIMEOUT_W(4)) dut (
        .iClock(clk), .iReset(iReset), .iRxDone(iRxDone), .iRxData(iRxData),
        .iSampleValid(iSampleValid), .iTxReady(iTxReady),
        .oFetchValue(oFetchValue), .oResetSerial(oResetSerial),
        .oStartSampling(oStartSampling), .oMemWrite(oMemWrite),
        .oMemAddr(oMemAddr), .oTxStart(oTxStart), .oBusy(oBusy),
        .oDone(oDone), .oError(oError)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_FETCH, EV_START, EV_WR, EV_TX, EV_DONE} ev_e;
    typedef struct {
        ev_e kind;
        int  addr;
        bit  err;
        int  cyc;
    } ev_t;

    ev_t sb[$];
    int  n_vec = 0, n_err = 0;
    int  cyc = 0, done_seen = 0, wr_seen = 0, tx_seen = 0;
    int  vmode = 1, rmode = 1, vlow = 0, rlow = 0;
    bit  chk_idle = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake drivers: 0 random (bounded stalls), 1 high, 2 low, 3 every 3rd,
    // 4 high until two writes, 5 high until two sends, 6 every 6th cycle.
    initial forever begin
        @(posedge clk);
        #1;
        case (vmode)
            0: begin
                if ($urandom_range(0, 2) == 0 && vlow < 4) begin
                    iSampleValid = 1'b0; vlow++;
                end else begin
                    iSampleValid = 1'b1; vlow = 0;
                end
            end
            1: iSampleValid = 1'b1;
            3: iSampleValid = (cyc % 3 == 0);
            4: iSampleValid = (wr_seen < 2);
            default: iSampleValid = 1'b0;
        endcase
        case (rmode)
            0: begin
                if ($urandom_range(0, 2) == 0 && rlow < 4) begin
                    iTxReady = 1'b0; rlow++;
                end else begin
                    iTxReady = 1'b1; rlow = 0;
                end
            end
            1: iTxReady = 1'b1;
            5: iTxReady = (tx_seen < 2);
            6: iTxReady = (cyc % 6 == 0);
            default: iTxReady = 1'b0;
        endcase
    end

    function automatic void push(ev_e k, int a, bit e, int c);
        ev_t x;
        x.kind = k; x.addr = a; x.err = e; x.cyc = c;
        sb.push_back(x);
    endfunction

    // kind: 0 nothing, 1 full run, 2 full run with exact timing (handshakes held high),
    // 3 stalled sample timeout, 4 first two writes only, 5 first two sends only.
    function automatic void model(logic [1:0] mode, int c0, int kind);
        int nw, nt;
        bit tm;
        if (kind == 0 || mode == 2'b11) return;
        tm = (kind == 2);
        push(EV_FETCH, 0, 0, c0 + 1);
        if (mode != 2'b10) push(EV_START, 0, 0, c0 + 2);
        if (kind == 3) begin
            push(EV_DONE, 0, 1, c0 + 3 + 15);
            return;
        end
        nw = (mode == 2'b10) ? 0 : (kind == 4 ? 2 : DEPTH);
        for (int i = 0; i < nw; i++) push(EV_WR, i, 0, tm ? c0 + 3 + i : -1);
        if (kind == 4) return;
        nt = (mode == 2'b01) ? 0 : (kind == 5 ? 2 : DEPTH);
        for (int i = 0; i < nt; i++)
            push(EV_TX, i, 0, tm ? c0 + 4 + DEPTH + 2 * i : -1);
        if (kind == 5) return;
        push(EV_DONE, 0, 0, tm ? c0 + 3 + 3 * DEPTH : -1);
    endfunction

    task automatic expect_ev(input ev_e k, input int a, input bit e);
        ev_t x;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s: unexpected event addr=%0d cycle=%0d, required none",
                     k.name(), a, cyc);
            return;
        end
        x = sb.pop_front();
        if (x.kind != k || x.addr != a || x.err != e || (x.cyc >= 0 && x.cyc != cyc)) begin
            n_err++;
            $display("FAIL event: got %s addr=%0d err=%0d cyc=%0d, required %s addr=%0d err=%0d cyc=%0d",
                     k.name(), a, e, cyc, x.kind.name(), x.addr, x.err, x.cyc);
        end
    endtask

    task automatic check(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_idle) begin
            chk_idle = 0;
            check("busy_after_done", int'(oBusy), 0);
        end
        if (oFetchValue) expect_ev(EV_FETCH, 0, oError);
        if (oStartSampling || oResetSerial) begin
            expect_ev(EV_START, 0, 1'b0);
            check("reset_serial_pair", int'(oResetSerial), int'(oStartSampling));
        end
        if (oMemWrite) begin
            expect_ev(EV_WR, int'(oMemAddr), 1'b0);
            wr_seen++;
        end
        if (oTxStart) begin
            expect_ev(EV_TX, int'(oMemAddr), 1'b0);
            tx_seen++;
        end
        if (oDone) begin
            expect_ev(EV_DONE, 0, oError);
            done_seen++;
            chk_idle = 1;
        end
    end

    task automatic issue(input logic [7:0] d, input int kind);
        @(posedge clk);
        #1;
        iRxDone = 1'b1;
        iRxData = d;
        model(d[7:6], cyc, kind);
        @(posedge clk);
        #1;
        iRxDone = 1'b0;
        iRxData = $urandom();
    endtask

    task automatic wait_done(input int n0, input int bound);
        int k = 0;
        while (done_seen == n0 && k < bound) begin
            @(posedge clk);
            k++;
        end
        n_vec++;
        if (done_seen == n0) begin
            n_err++;
            $display("FAIL done_wait: no oDone within %0d cycles, required one", bound);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_count(input string nm, input int which, input int want);
        int k = 0;
        while ((which == 0 ? wr_seen : tx_seen) < want && k < 60) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(nm, (which == 0 ? wr_seen : tx_seen), want);
    endtask

    initial begin
        int n0;
        logic [1:0] m;
        iReset = 1'b1; iRxDone = 1'b0; iRxData = 8'h00;
        iSampleValid = 1'b0; iTxReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(oBusy), 0);
        check("rst_addr", int'(oMemAddr), 0);
        check("rst_error", int'(oError), 0);
        check("rst_done", int'(oDone), 0);
        iReset = 1'b0;

        // sample+send with handshakes held high, plus a stray command in the DONE cycle
        vmode = 1; rmode = 1;
        n0 = done_seen;
        issue(8'h00, 2);
        repeat (13) @(posedge clk);
        issue(8'h40, 0);
        wait_done(n0, 10);
        check("no_error_run1", int'(oError), 0);
        check("stray_in_done_idle", int'(oBusy), 0);

        // sample-only, valid every third cycle
        vmode = 3;
        n0 = done_seen;
        issue(8'h40, 1);
        wait_done(n0, 60);

        // send-only, ready every sixth cycle
        rmode = 6;
        n0 = done_seen;
        issue(8'h80, 1);
        wait_done(n0, 80);

        // mode 11 is ignored in idle
        issue(8'hC0, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("mode11_idle", int'(oBusy), 0);
        end

        // sample-only stalled forever: watchdog timeout, then cleared by next command
        vmode = 2;
        n0 = done_seen;
        issue(8'h40, 3);
        wait_done(n0, 40);
        check("error_sticky", int'(oError), 1);
        vmode = 0;
        n0 = done_seen;
        issue(8'h40, 1);
        wait_done(n0, 60);
        check("error_cleared", int'(oError), 0);

        // reset while waiting on the third send byte
        tx_seen = 0; rmode = 5;
        issue(8'h80, 5);
        wait_count("tx_before_reset", 1, 2);
        repeat (3) @(posedge clk);
        #1;
        check("stall_addr", int'(oMemAddr), 2);
        check("stall_busy", int'(oBusy), 1);
        check("sb_empty_at_reset", sb.size(), 0);
        sb.delete();
        iReset = 1'b1;
        @(posedge clk);
        #1;
        iReset = 1'b0;
        check("mid_rst_addr", int'(oMemAddr), 0);
        check("mid_rst_busy", int'(oBusy), 0);
        check("mid_rst_tx", int'(oTxStart), 0);
        vmode = 1; rmode = 1;
        n0 = done_seen;
        issue(8'h00, 2);
        wait_done(n0, 30);

        // 8'hFF while sampling after two writes
        wr_seen = 0; vmode = 4;
        n0 = done_seen;
        issue(8'h40, 4);
        wait_count("writes_before_ff", 0, 2);
`ifdef CIRC_SEQ_FSM_ABORT_EN
        push(EV_DONE, 0, 1, -1);
        issue(8'hFF, 0);
        wait_done(n0, 10);
        check("abort_error", int'(oError), 1);
`else
        push(EV_WR, 2, 0, -1);
        push(EV_WR, 3, 0, -1);
        push(EV_DONE, 0, 0, -1);
        issue(8'hFF, 0);
        vmode = 0;
        wait_done(n0, 30);
        check("ff_ignored_error", int'(oError), 0);
`endif

        // randomized commands and handshakes
        vmode = 0; rmode = 0;
        for (int t = 0; t < 10; t++) begin
            m = 2'($urandom_range(0, 2));
            n0 = done_seen;
            issue({m, 6'($urandom())}, 1);
            wait_done(n0, 100);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        check("sb_empty_end", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
